instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 121 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch engine feeding a DEPTH-entry FIFO
// of {pc, instr} pairs, with redirect flush and drain of a stale in-flight request.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  count
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_W = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_ins [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic          push;
  logic          pop;
  logic [3:0]    count_next;
  logic [31:0]   redirect_aligned;
  logic [31:0]   fetch_pc_inc;

  always_comb begin
    push             = (state == FETCH) && mem_ack && !redirect;
    pop              = deq && (count != '0) && !redirect;
    count_next       = count + {3'b000, push} - {3'b000, pop};
    redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    fetch_pc_inc     = fetch_pc + 32'd4;
  end

  // mem_addr follows fetch_pc except in DRAIN, where the in-flight address is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= redirect_aligned;
      mem_req  <= 1'b1;
      if ((state != IDLE) && !mem_ack) begin
        state <= DRAIN;
      end else begin
        state    <= FETCH;
        mem_addr <= redirect_aligned;
      end
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      count <= count_next;
      case (state)
        IDLE: begin
          if (count_next < DEPTH_W) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc_inc;
            mem_addr <= fetch_pc_inc;
            if (count_next == DEPTH_W) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state    <= FETCH;
            mem_addr <= fetch_pc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]  <= fetch_pc;
      q_ins[tail] <= mem_rdata;
    end
  end

  always_comb begin
    valid    = (count != '0);
    instr    = valid ? q_ins[head] : '0;
    pc       = valid ? q_pc[head] : '0;
    pc_plus4 = valid ? (q_pc[head] + 32'd4) : '0;
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model (entry queue + one outstanding-request record).
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  logic [31:0] key;
  bit          m_out;
  bit          m_stale;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .valid(valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_fpc   = RESET_PC;
    m_addr  = RESET_PC;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endtask

  // One clock of the reference model: redirect flushes and either re-targets or
  // turns the in-flight request stale; otherwise pop, retire the ack, then refill.
  task automatic m_step(input bit r, input logic [31:0] rp, input bit d, input bit a,
                        input logic [31:0] data);
    bit ack_eff;
    bit popit;
    ack_eff = m_out && a;
    if (r) begin
      m_q.delete();
      m_fpc = rp & 32'hFFFF_FFFC;
      if (m_out && !ack_eff) begin
        m_stale = 1'b1;
      end else begin
        m_out = 1'b1; m_addr = m_fpc; m_stale = 1'b0;
      end
    end else begin
      popit = d && (m_q.size() != 0);
      if (popit) void'(m_q.pop_front());
      if (ack_eff) begin
        if (!m_stale) begin
          m_q.push_back('{pc: m_fpc, ins: data});
          m_fpc = m_fpc + 32'd4;
        end
        m_out = 1'b0;
      end
      if (!m_out && (m_q.size() < DEPTH)) begin
        m_out = 1'b1; m_addr = m_fpc; m_stale = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] e_ins, e_pc, e_p4;
    bit ev;
    ev = (m_q.size() != 0);
    e_ins = '0; e_pc = '0; e_p4 = '0;
    if (ev) begin
      e_ins = m_q[0].ins;
      e_pc  = m_q[0].pc;
      e_p4  = m_q[0].pc + 32'd4;
    end
    chk("valid",    {31'b0, valid},   {31'b0, ev});
    chk("count",    {28'b0, count},   32'(m_q.size()));
    chk("instr",    instr,            e_ins);
    chk("pc",       pc,               e_pc);
    chk("pc_plus4", pc_plus4,         e_p4);
    chk("mem_req",  {31'b0, mem_req}, {31'b0, m_out});
    chk("mem_addr", mem_addr,         m_out ? m_addr : m_fpc);
  endtask

  task automatic cyc(input bit r, input logic [31:0] rp, input bit d, input bit a);
    logic [31:0] data;
    @(negedge clk);
    data        = (m_out ? m_addr : m_fpc) ^ key;
    redirect    = r;
    redirect_pc = rp;
    deq         = d;
    mem_ack     = a;
    mem_rdata   = data;
    check_all();
    @(posedge clk);
    m_step(r, rp, d, a, data);
  endtask

  // Reset lands mid-cycle so its asynchronous effect is observed before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; redirect = 1'b0; deq = 1'b0; mem_ack = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    key = '0;
    m_reset();

    phase = "reset";
    do_reset();

    phase = "stream";
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1, 1'b1);

    phase = "fill";
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("full_count", {28'b0, count}, 32'd4);
    chk("full_req",   {31'b0, mem_req}, 32'd0);
    chk("full_addr",  mem_addr, 32'd16);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b1);

    phase = "drain";
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("pend_addr", mem_addr, 32'd8);
    cyc(1'b1, 32'h0000_0103, 1'b0, 1'b0);
    #1;
    chk("drain_req",   {31'b0, mem_req}, 32'd1);
    chk("drain_addr",  mem_addr, 32'd8);
    chk("drain_count", {28'b0, count}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("refetch_addr",  mem_addr, 32'h0000_0100);
    chk("refetch_valid", {31'b0, valid}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("first_pc", pc, 32'h0000_0100);
    cyc(1'b0, '0, 1'b1, 1'b0);

    phase = "redir_ack";
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("pre_count", {28'b0, count}, 32'd3);
    cyc(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    #1;
    chk("post_count", {28'b0, count}, 32'd0);
    chk("post_valid", {31'b0, valid}, 32'd0);
    chk("post_addr",  mem_addr, 32'h0000_0040);
    cyc(1'b0, '0, 1'b0, 1'b1);

    phase = "wrap";
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("wrap_pc",   pc, 32'hFFFF_FFFC);
    chk("wrap_p4",   pc_plus4, 32'h0);
    chk("wrap_next", mem_addr, 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    phase = "mid_reset";
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("busy_count", {28'b0, count}, 32'd3);
    chk("busy_req",   {31'b0, mem_req}, 32'd1);
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("restart_req",  {31'b0, mem_req}, 32'd1);
    chk("restart_addr", mem_addr, RESET_PC);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      key = $urandom;
      cyc($urandom_range(0, 15) == 0, $urandom,
          (i < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 3) != 0);
      if ((i % 200) == 199) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
